dm_dump_unit: RTL and testbench

- Post-execution dump engine for the BIP data memory.
- Reads dm_ram words sequentially by driving its address and Rd inputs and capturing its o_Data.
- Serializes each 16-bit word into two bytes for the UART transmitter, high byte first, with a start/done handshake per byte.
- Sits between dm_ram (upstream data source) and the UART tx (downstream sink).
- Its address and Rd outputs are multiplexed onto dm_ram by the debug unit while the CPU is halted.

---
 rtl/dm_dump_unit.sv | 126 ++++++++++++
 tb/tb_dm_dump_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_dump_unit.sv
// Dump engine: walks dm_ram from address 0 to DUMP_WORDS-1 and streams each
// word to the UART transmitter as two bytes, high byte first.
module dm_dump_unit #(
   parameter int ADDR_LENGTH = 11,
   parameter int DATA_LENGTH = 16,
   parameter int DUMP_WORDS  = 512,
   parameter int BYTE_WIDTH  = 8
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_start,
   output logic [ADDR_LENGTH-1:0] o_Addr,
   output logic                   o_Rd,
   input  logic [DATA_LENGTH-1:0] i_Data,
   output logic [BYTE_WIDTH-1:0]  o_tx_data,
   output logic                   o_tx_start,
   input  logic                   i_tx_done,
   output logic                   o_busy,
   output logic                   o_done
);

   // state   | meaning
   // IDLE    | waiting for i_start
   // READ    | o_Rd high, address presented
   // LATCH   | o_Rd held, word captured from i_Data
   // SEND_HI | launch high byte
   // WAIT_HI | wait for tx done of high byte
   // SEND_LO | launch low byte
   // WAIT_LO | wait for tx done of low byte
   // NEXT    | last-word compare, else advance address
   // DONE    | completion pulse, address back to 0
   typedef enum logic [3:0] {
      IDLE, READ, LATCH, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, NEXT, DONE
   } state_t;

   localparam logic [ADDR_LENGTH-1:0] LAST_ADDR = ADDR_LENGTH'(DUMP_WORDS - 1);

   state_t                 state_q, state_d;
   logic [ADDR_LENGTH-1:0] cnt_q, cnt_d;
   logic [DATA_LENGTH-1:0] word_q, word_d;
   logic [BYTE_WIDTH-1:0]  tx_data_q, tx_data_d;
   logic                   rd_q, rd_d;
   logic                   tx_start_q, tx_start_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      case (state_q)
         IDLE: begin
            if (i_start) begin
               cnt_d   = '0;
               state_d = READ;
            end
         end
         READ:    state_d = LATCH;
         LATCH: begin
            word_d  = i_Data;
            state_d = SEND_HI;
         end
         SEND_HI: state_d = WAIT_HI;
         WAIT_HI: if (i_tx_done) state_d = SEND_LO;
         SEND_LO: state_d = WAIT_LO;
         WAIT_LO: if (i_tx_done) state_d = NEXT;
         NEXT: begin
            // compare before increment so a full-range dump never wraps
            if (cnt_q == LAST_ADDR) begin
               state_d = DONE;
            end else begin
               cnt_d   = cnt_q + ADDR_LENGTH'(1);
               state_d = READ;
            end
         end
         DONE: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // outputs are registered from the next state so they align with it
   always_comb begin
      rd_d       = (state_d == READ) || (state_d == LATCH);
      tx_start_d = (state_d == SEND_HI) || (state_d == SEND_LO);
      busy_d     = (state_d != IDLE);
      done_d     = (state_d == DONE);
      tx_data_d  = tx_data_q;
      if (state_d == SEND_HI)
         tx_data_d = word_d[DATA_LENGTH-1 -: BYTE_WIDTH];
      else if (state_d == SEND_LO)
         tx_data_d = word_d[BYTE_WIDTH-1:0];
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         word_q     <= '0;
         tx_data_q  <= '0;
         rd_q       <= 1'b0;
         tx_start_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         word_q     <= word_d;
         tx_data_q  <= tx_data_d;
         rd_q       <= rd_d;
         tx_start_q <= tx_start_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign o_Addr     = cnt_q;
   assign o_Rd       = rd_q;
   assign o_tx_data  = tx_data_q;
   assign o_tx_start = tx_start_q;
   assign o_busy     = busy_q;
   assign o_done     = done_q;

endmodule

// File: tb/tb_dm_dump_unit.sv
// Bench for dm_dump_unit: scoreboard of expected tx bytes, UART responder,
// and a second single-word instance.
module tb_dm_dump_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start;
   logic [10:0] addr;
   logic        rd;
   logic [15:0] data;
   logic [7:0]  tx_data;
   logic        tx_start, tx_done, busy, done;
   logic        real_done, spur_done, tx_hold;
   int          mode;
   logic [15:0] mem [4];

   assign data    = mem[addr[1:0]];
   assign tx_done = real_done | spur_done | tx_hold;

   logic        start1;
   logic [10:0] addr1;
   logic        rd1;
   logic [15:0] data1;
   logic [7:0]  tx_data1;
   logic        tx_start1, tx_done1, busy1, done1;

   dm_dump_unit #(.ADDR_LENGTH(11), .DATA_LENGTH(16), .DUMP_WORDS(4), .BYTE_WIDTH(8)) dut (
      .i_clk(clk), .i_reset(rst), .i_start(start), .o_Addr(addr), .o_Rd(rd),
      .i_Data(data), .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_done(tx_done),
      .o_busy(busy), .o_done(done));

   dm_dump_unit #(.ADDR_LENGTH(11), .DATA_LENGTH(16), .DUMP_WORDS(1), .BYTE_WIDTH(8)) dut1 (
      .i_clk(clk), .i_reset(rst), .i_start(start1), .o_Addr(addr1), .o_Rd(rd1),
      .i_Data(data1), .o_tx_data(tx_data1), .o_tx_start(tx_start1), .i_tx_done(tx_done1),
      .o_busy(busy1), .o_done(done1));

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   logic [7:0] exp_q [$];
   int cyc = 0, start_cnt = 0, done_cnt = 0, busy_cycles = 0, byte_idx = 0, last_start = 0;
   int hl_gap = 4, lh_gap = 7;
   int rd_cycles [4];
   logic prev_busy = 1'b0, prev_done = 1'b0;

   // monitor for the 4-word instance
   initial forever begin
      @(negedge clk);
      cyc++;
      if (tx_start) begin
         check("queue_nonempty_at_tx_start", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) check("tx_byte", tx_data, exp_q.pop_front());
         if (byte_idx % 2 == 1) check("gap_hi_to_lo", cyc - last_start, hl_gap);
         else if (byte_idx > 0) check("gap_lo_to_hi", cyc - last_start, lh_gap);
         last_start = cyc;
         byte_idx++;
         start_cnt++;
      end
      if (done) done_cnt++;
      if (busy) busy_cycles++;
      if (rd) rd_cycles[addr[1:0]]++;
      if (prev_busy && !busy && !rst) check("done_with_busy_fall", prev_done, 1);
      prev_busy = busy;
      prev_done = done;
   end

   // UART responder: done pulse 3 cycles after each start
   initial begin
      int cd;
      cd = 0;
      real_done = 1'b0;
      forever begin
         @(negedge clk);
         real_done = 1'b0;
         if (cd > 0) begin
            cd--;
            if (cd == 0) real_done = 1'b1;
         end
         if (tx_start && mode != 1) cd = 3;
      end
   end

   // spurious done during LATCH and SEND_* cycles in mode 2
   initial begin
      logic rd_prev;
      rd_prev = 1'b0;
      spur_done = 1'b0;
      forever begin
         @(negedge clk);
         spur_done = (mode == 2) && (tx_start || (rd && rd_prev));
         rd_prev = rd;
      end
   end

   logic [7:0] b1 [4];
   int n1 = 0, d1 = 0;
   logic addr1_bad = 1'b0;
   initial forever begin
      @(negedge clk);
      if (tx_start1 && n1 < 4) b1[n1] = tx_data1;
      if (tx_start1) n1++;
      if (done1) d1++;
      if (addr1 != 11'd0) addr1_bad = 1'b1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic clear_stats();
      start_cnt = 0; done_cnt = 0; busy_cycles = 0; byte_idx = 0;
      for (int i = 0; i < 4; i++) rd_cycles[i] = 0;
   endtask

   task automatic push_word(input logic [15:0] w);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
   endtask

   task automatic push_all();
      for (int i = 0; i < 4; i++) push_word(mem[i]);
   endtask

   task automatic do_start();
      @(negedge clk); #1 start = 1'b1;
      @(negedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int k;
      k = 0;
      do begin
         @(negedge clk); #1;
         k++;
      end while (busy && k < budget);
      check(tag, busy, 0);
   endtask

   task automatic wait_starts(input string tag, input int n, input int budget);
      int k;
      k = 0;
      while (start_cnt < n && k < budget) begin
         @(negedge clk); #1;
         k++;
      end
      check(tag, start_cnt >= n, 1);
   endtask

   task automatic end_checks(input string tag);
      check({tag, "_start_count"}, start_cnt, 8);
      check({tag, "_done_count"}, done_cnt, 1);
      check({tag, "_queue_empty"}, exp_q.size(), 0);
      check({tag, "_addr_end"}, addr, 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; start1 = 1'b0; mode = 0; tx_hold = 1'b0;
      tx_done1 = 1'b1; data1 = 16'h00FF;
      mem[0] = 16'h1234; mem[1] = 16'h0034; mem[2] = 16'hABCD; mem[3] = 16'hFFFF;
      #12;
      check("rst_addr", addr, 0);
      check("rst_rd", rd, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_tx_start", tx_start, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_busy1", busy1, 0);
      @(negedge clk); #1 rst = 1'b0;

      // 1: done pulsed 3 cycles after each start
      clear_stats(); hl_gap = 4; lh_gap = 7;
      push_all();
      do_start();
      wait_idle("s1_idle", 300);
      end_checks("s1");

      // 2: done held high, minimum latency
      clear_stats(); mode = 1; tx_hold = 1'b1; hl_gap = 2; lh_gap = 5;
      push_all();
      do_start();
      wait_idle("s2_idle", 300);
      end_checks("s2");
      check("s2_busy_cycles", busy_cycles, 29);
      for (int i = 0; i < 4; i++) check("s2_rd_cycles", rd_cycles[i], 2);
      mode = 0; tx_hold = 1'b0; hl_gap = 4; lh_gap = 7;
      repeat (2) @(negedge clk);

      // 3: second start during WAIT_HI of word 1 is ignored
      clear_stats();
      push_all();
      do_start();
      wait_starts("s3_reach_word1", 3, 300);
      @(negedge clk); #1 start = 1'b1;
      @(negedge clk); #1 start = 1'b0;
      wait_idle("s3_idle", 300);
      end_checks("s3");
      repeat (10) @(negedge clk);
      check("s3_no_restart", start_cnt, 8);

      // 4: spurious done pulses in LATCH and SEND_* do not skip waits
      clear_stats(); mode = 2;
      push_all();
      do_start();
      wait_idle("s4_idle", 300);
      end_checks("s4");
      mode = 0;
      repeat (6) @(negedge clk);

      // 5: async reset mid-cycle in WAIT_LO of word 2
      clear_stats();
      push_all();
      do_start();
      wait_starts("s5_reach_word2_lo", 6, 300);
      @(posedge clk); #2 rst = 1'b1;
      #1;
      check("s5_rst_addr", addr, 0);
      check("s5_rst_rd", rd, 0);
      check("s5_rst_tx_data", tx_data, 0);
      check("s5_rst_tx_start", tx_start, 0);
      check("s5_rst_busy", busy, 0);
      check("s5_rst_done", done, 0);
      repeat (6) @(negedge clk);
      #1;
      check("s5_no_start_in_reset", start_cnt, 6);
      check("s5_leftover_bytes", exp_q.size(), 2);
      exp_q.delete();
      rst = 1'b0;
      mem[0] = 16'h0012;
      clear_stats();
      push_all();
      do_start();
      wait_idle("s5_restart_idle", 300);
      end_checks("s5");

      // 6: single-word instance
      @(negedge clk); #1 start1 = 1'b1;
      @(negedge clk); #1 start1 = 1'b0;
      for (int k = 0; k < 50 && busy1; k++) begin
         @(negedge clk); #1;
      end
      check("s6_idle", busy1, 0);
      check("s6_byte_count", n1, 2);
      check("s6_byte0", b1[0], 8'h00);
      check("s6_byte1", b1[1], 8'hFF);
      check("s6_done_count", d1, 1);
      check("s6_addr_stayed_zero", addr1_bad, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
